// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: pin synchronizer, 11-bit frame deframer with idle timeout,
// scancode FIFO with ready/nextdata_n pop, and a make/break decoder for key events.
module ps2_keyboard #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err,
    output logic       key_we,
    output logic [7:0] key_code,
    output logic [7:0] key_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    // Pin synchronizers; idle-high reset values avoid a false edge after reset.
    logic [2:0] clk_sync;
    logic [1:0] dat_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    logic fall_c;
    assign fall_c = (clk_sync[2:1] == 2'b10);

    // Deframer: shift register holds the previous ten bits, newest at the top.
    logic [3:0]  bit_cnt;
    logic [9:0]  shift;
    logic [15:0] idle_cnt;

    logic [10:0] frame_c;
    logic        last_bit_c;
    logic        frame_ok_c;
    logic        frame_valid_c;
    logic [7:0]  code_c;

    assign frame_c       = {dat_sync[1], shift};
    assign last_bit_c    = fall_c && (bit_cnt == 4'd10);
    assign frame_ok_c    = !frame_c[0] && frame_c[10] && (^frame_c[9:1]);
    assign frame_valid_c = last_bit_c && frame_ok_c;
    assign code_c        = frame_c[8:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 4'd0;
            shift    <= 10'd0;
            idle_cnt <= 16'd0;
        end else if (fall_c) begin
            idle_cnt <= 16'd0;
            shift    <= frame_c[10:1];
            bit_cnt  <= last_bit_c ? 4'd0 : bit_cnt + 4'd1;
        end else begin
            if (idle_cnt != TIMEOUT) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            // Stalled partial frame: drop it silently.
            if ((idle_cnt == TIMEOUT) && (bit_cnt != 4'd0)) begin
                bit_cnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (last_bit_c && !frame_ok_c) begin
            frame_err <= 1'b1;
        end
    end

    // Scancode FIFO with one extra pointer bit to tell full from empty.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic empty_c;
    logic full_c;
    logic pop_c;
    logic push_c;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c   = !nextdata_n && !empty_c;
    assign push_c  = frame_valid_c && (!full_c || pop_c);

    assign ready = !empty_c;
    assign data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push_c) begin
                mem[wr_ptr[AW-1:0]] <= code_c;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (frame_valid_c && full_c && !pop_c) begin
            overflow <= 1'b1;
        end
    end

    // Make/break decoder: one event per fresh key press, repeats of the held key suppressed.
    logic       break_pend;
    logic       held;
    logic [7:0] held_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            break_pend <= 1'b0;
            held       <= 1'b0;
            held_code  <= 8'h00;
            key_we     <= 1'b0;
            key_code   <= 8'h00;
            key_cnt    <= 8'h00;
        end else begin
            key_we <= 1'b0;
            if (frame_valid_c) begin
                if (code_c == CODE_BREAK) begin
                    break_pend <= 1'b1;
                end else if (code_c == CODE_EXT) begin
                    break_pend <= break_pend;
                end else if (break_pend) begin
                    break_pend <= 1'b0;
                    if (code_c == held_code) begin
                        held <= 1'b0;
                    end
                end else if (!(held && (code_c == held_code))) begin
                    held_code <= code_c;
                    held      <= 1'b1;
                    key_code  <= code_c;
                    key_cnt   <= key_cnt + 8'd1;
                    key_we    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: random and directed PS/2 frames against a
// behavioural model of the FIFO contents and key-press events.
module tb_ps2_keyboard;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 200;
    localparam int unsigned HALF  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;
    logic       key_we;
    logic [7:0] key_code;
    logic [7:0] key_cnt;

    ps2_keyboard #(.FIFO_DEPTH(DEPTH), .TIMEOUT(16'(TMO))) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .key_we     (key_we),
        .key_code   (key_code),
        .key_cnt    (key_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    bit pop_en   = 1'b0;

    logic [7:0]  exp_fifo[$];
    logic [15:0] exp_key[$];

    // Reference model state
    bit         m_brk;
    bit         m_held;
    logic [7:0] m_hc;
    logic [7:0] m_cnt;
    bit         m_ferr;
    bit         m_ovf;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void model_reset();
        m_brk = 0; m_held = 0; m_hc = 8'h00; m_cnt = 8'h00; m_ferr = 0; m_ovf = 0;
        exp_fifo.delete();
        exp_key.delete();
    endfunction

    function automatic void model_frame(input logic [7:0] code, input bit bad);
        if (bad) begin
            m_ferr = 1;
            return;
        end
        if (exp_fifo.size() < DEPTH) exp_fifo.push_back(code);
        else m_ovf = 1;
        if (code == 8'hF0) m_brk = 1;
        else if (code == 8'hE0) begin end
        else if (m_brk) begin
            m_brk = 0;
            if (code == m_hc) m_held = 0;
        end else if (!(m_held && code == m_hc)) begin
            m_hc = code;
            m_held = 1;
            m_cnt = m_cnt + 8'd1;
            exp_key.push_back({code, m_cnt});
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad);
        logic par;
        par = ~(^code) ^ bad;
        model_frame(code, bad);
        send_bits({1'b1, par, code, 1'b0}, 11);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_fifo.size() != 0 || exp_key.size() != 0) && k < 1000) begin
            tick(1);
            k++;
        end
        tick(4);
        check("drain_fifo_left", 16'(exp_fifo.size()), 16'd0);
        check("drain_keys_left", 16'(exp_key.size()), 16'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_data", 16'(data), 16'h0);
        check("rst_ready", 16'(ready), 16'h0);
        check("rst_overflow", 16'(overflow), 16'h0);
        check("rst_frame_err", 16'(frame_err), 16'h0);
        check("rst_key_we", 16'(key_we), 16'h0);
        check("rst_key_code", 16'(key_code), 16'h0);
        check("rst_key_cnt", 16'(key_cnt), 16'h0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"}, 16'(frame_err), 16'(m_ferr));
        check({tag, "_overflow"}, 16'(overflow), 16'(m_ovf));
        check({tag, "_key_cnt"}, 16'(key_cnt), 16'(m_cnt));
    endtask

    // Monitor: pops FIFO entries and key events, comparing against the model queues.
    always @(negedge clk) begin
        logic [15:0] ev;
        nextdata_n = 1'b1;
        if (!rst) begin
            if (ready && pop_en) begin
                if (exp_fifo.size() == 0) check("unexpected_data", 16'(data), 16'hFFFF);
                else check("fifo_data", 16'(data), 16'(exp_fifo.pop_front()));
                nextdata_n = 1'b0;
            end
            if (key_we) begin
                pulses++;
                if (exp_key.size() == 0) check("unexpected_key_we", 16'(key_code), 16'hFFFF);
                else begin
                    ev = exp_key.pop_front();
                    check("key_code", 16'(key_code), 16'(ev[15:8]));
                    check("key_cnt_at_we", 16'(key_cnt), 16'(ev[7:0]));
                end
            end
        end
    end

    initial begin
        int p0;
        logic [7:0] pool[6];
        logic [7:0] c;
        pool[0] = 8'h1C; pool[1] = 8'h1B; pool[2] = 8'h23;
        pool[3] = 8'hF0; pool[4] = 8'hE0; pool[5] = 8'h2A;

        model_reset();
        tick(5);
        check_reset_outputs();
        rst = 1'b0;
        tick(3);
        pop_en = 1'b1;

        // Single key press and release
        p0 = pulses;
        send_frame(8'h1C, 0); send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        drain();
        check("single_pulses", 16'(pulses - p0), 16'd1);
        check("single_key_code", 16'(key_code), 16'h1C);
        check_flags("single");

        // Auto-repeat suppression
        p0 = pulses;
        send_frame(8'h1C, 0); send_frame(8'h1C, 0); send_frame(8'h1C, 0);
        send_frame(8'hF0, 0); send_frame(8'h1C, 0); send_frame(8'h1C, 0);
        drain();
        check("repeat_pulses", 16'(pulses - p0), 16'd2);
        check_flags("repeat");

        // Partial frame discarded by idle timeout
        send_bits(11'h0F6, 5);
        tick(TMO + 10);
        send_frame(8'h2A, 0);
        drain();
        check_flags("timeout");

        // Bad parity, then a good frame still accepted
        p0 = pulses;
        send_frame(8'h1C, 1);
        tick(2);
        check("badpar_ready", 16'(ready), 16'h0);
        check("badpar_pulses", 16'(pulses - p0), 16'd0);
        send_frame(8'h33, 0);
        drain();
        check_flags("badpar");

        // Overflow with pops disabled
        pop_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            c = 8'(8'h40 + i);
            send_frame(c, 0);
        end
        tick(2);
        check("ovf_ready", 16'(ready), 16'h1);
        check("ovf_depth", 16'(exp_fifo.size()), 16'(DEPTH));
        check_flags("ovf");
        pop_en = 1'b1;
        drain();
        check("ovf_ready_after", 16'(ready), 16'h0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            c = pool[$urandom_range(5, 0)];
            send_frame(c, ($urandom_range(7, 0) == 0));
        end
        drain();
        check_flags("random");

        // Reset in the middle of a frame
        send_bits(11'h2B4, 6);
        rst = 1'b1;
        tick(2);
        model_reset();
        check_reset_outputs();
        rst = 1'b0;
        tick(3);
        send_frame(8'h15, 0);
        drain();
        check_flags("midrst");

        // key_cnt wrap over 256 make/break pairs
        rst = 1'b1;
        tick(2);
        model_reset();
        rst = 1'b0;
        tick(3);
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            c = 8'(8'h01 + (i % 100));
            send_frame(c, 0);
            send_frame(8'hF0, 0);
            send_frame(c, 0);
        end
        drain();
        check("wrap_pulses", 16'(pulses - p0), 16'd256);
        check("wrap_key_cnt", 16'(key_cnt), 16'h00);
        check_flags("wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard front end for the keyboard-to-screen text path. It samples the raw `ps2_clk`/`ps2_data` pins and deframes 11-bit PS/2 frames. Valid scancodes are buffered in a small FIFO with a ready/nextdata_n pop handshake. In parallel, a make/break decoder emits one write pulse per new key press (`key_we`, `key_code`, `key_cnt`) for the downstream scancode-to-ASCII character buffer.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: scancode FIFO entries; must be a power of two, at least 2.
- `TIMEOUT`, 16'd50000: idle `clk` cycles after which a partial frame is discarded.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`, idle high.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `nextdata_n`  in  1  active-low pop request for the FIFO head.
- `data`  out  8  FIFO head scancode; valid only while `ready`=1.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky; a valid frame was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a frame failed its start, stop or parity check.
- `key_we`  out  1  one-cycle pulse per new make event.
- `key_code`  out  8  scancode of the most recent make event; holds its value between events.
- `key_cnt`  out  8  count of make events; wraps 8'hFF→8'h00.

## Operation
- **Synchronizer:** `ps2_clk` passes through a 3-flop chain. A falling edge is detected when stages [2:1] equal 2'b10. `ps2_data` goes through a 2-flop chain and is sampled on the detected edge.
- **Deframer:** a 4-bit bit counter runs 0..10, and the sampled bits fill an 11-bit shift register. On the 11th edge the frame is checked:
  - start bit = 0
  - stop bit = 1
  - XOR of data[7:0] and the parity bit = 1 (odd parity)
- Pass → the frame is valid. Fail → `frame_err` is set and nothing is pushed. In both cases the counter returns to 0.
- **Timeout:** an idle counter clears on each detected edge. If it reaches `TIMEOUT` while the bit counter is non-zero, the partial frame is discarded and the counter returns to 0. No error flag is set.
- **FIFO:** read and write pointers are `log2(FIFO_DEPTH)+1` bits wide. Empty is pointers equal; full is MSBs differ and the rest equal.
  - A valid frame is pushed unless the FIFO is full.
  - Full with no pop in the same cycle → the frame is dropped and `overflow` is set.
  - Full with a pop in the same cycle → the push is accepted.
  - A pop occurs on a `clk` edge where `nextdata_n`=0 and `ready`=1. A pop request while empty is ignored, even if a push happens in the same cycle.
- **Make/break decoder:** every valid frame is decoded, whether or not it was pushed.
  - 8'hF0 → sets `break_pend`.
  - 8'hE0 → ignored; no state change.
  - Any other code with `break_pend`=1 → clears `break_pend`; if the code equals `held_code`, clears `held`. No event.
  - Any other code with `break_pend`=0 → if `held`=1 and the code equals `held_code`, it is auto-repeat and produces no event. Otherwise it is a make event: `held_code`←code, `held`←1, `key_code`←code, `key_cnt`←`key_cnt`+1, `key_we` pulses.
- `overflow` and `frame_err` are cleared only by `rst`.

## Timing
- **Reset:** `data`=0, `ready`=0, `overflow`=0, `frame_err`=0, `key_we`=0, `key_code`=0, `key_cnt`=0. Pointers, bit counter, idle counter, `held` and `break_pend` are all 0. Synchronizer flops reset to 1.
- **Reset mid-frame:** the partial frame is lost and the next frame is received normally.
- **Input latency:** a falling edge on the pin is detected 2–3 `clk` cycles later.
- **Completion:** the push and decode happen on the `clk` edge that detects the 11th falling edge. `ready` rises and `key_we` pulses in the following cycle, together.
- **`data`:** driven combinationally from the entry at the read pointer. After a pop, the next entry (or don't-care if empty) appears in the next cycle.
- **Back-to-back events:** `key_we` is never high for more than one cycle per event. Successive events are at least one frame apart.

## Test plan
- **Single key:** send frame 8'h1C (make 'A'), then F0, 1C → `ready`=1 with `data`=8'h1C, 8'hF0, 8'h1C popped in order. Exactly one `key_we` pulse with `key_code`=8'h1C; `key_cnt`=1.
- **Auto-repeat:** 1C ×3, then F0 1C, then 1C → exactly two `key_we` pulses; `key_cnt`=2.
- **Bad parity:** send 8'h1C with even parity → `frame_err`=1, `ready` stays 0, no `key_we`. A following good frame is still accepted.
- **Overflow:** send 9 frames with `nextdata_n` held high → first 8 are stored, `overflow`=1 after the 9th. Popping 8 times returns the first 8 codes in order, then `ready`=0.
- **Timeout and reset:** stop after 5 bits and idle `TIMEOUT`+1 cycles, then send a full 8'h2A → only 8'h2A received, `frame_err`=0. Assert `rst` mid-frame → all outputs return to reset values.
- **Counter wrap:** 256 distinct make/break pairs → `key_cnt` returns to 8'h00 with exactly 256 `key_we` pulses.
